// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg
//   Shared definitions for the pipeline hazard controller: forward-select
//   codes, divider sequencer states, counter width and the register tag
//   match helper. Imported by the interface, the top and div_sequencer.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_WB    = 2'b10;

  // Wide enough for DIV_CYCLES-1 with DIV_CYCLES up to 64.
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_t;

  // Register 0 is hardwired to zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] rd);
    return (rd != 5'd0) && (rd == src);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
//   Bundles the decode fields, pipeline register tags and controller outputs
//   exchanged between the MIPS pipeline and pipe_hazard_ctrl.
//   master : pipeline side (drives ID/EX/MEM/WB fields, reads stall/forward/div status)
//   slave  : controller side (pipe_hazard_ctrl)
interface pipe_hazard_ctrl_if;

  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic        ID_uses_rs;
  logic        ID_uses_rt;
  logic        ID_Beq;
  logic        ID_div_start;
  logic        ID_hilo_use;
  logic        ID_EX_RegWrite;
  logic        ID_EX_Mem2Reg;
  logic [4:0]  ID_EX_Rd;
  logic        EX_MEM_RegWrite;
  logic        EX_MEM_Mem2Reg;
  logic [4:0]  EX_MEM_Rd;
  logic        MEM_WB_RegWrite;
  logic [4:0]  MEM_WB_Rd;
  logic        EX_MEM_branch_tacken;
  logic        stall;
  logic [3:0]  forwardSignal;
  logic        div_busy;
  logic        div_done;
  logic [31:0] stall_cycles;

  modport master (
    output ID_Rs, ID_Rt, ID_uses_rs, ID_uses_rt, ID_Beq, ID_div_start, ID_hilo_use,
           ID_EX_RegWrite, ID_EX_Mem2Reg, ID_EX_Rd,
           EX_MEM_RegWrite, EX_MEM_Mem2Reg, EX_MEM_Rd,
           MEM_WB_RegWrite, MEM_WB_Rd, EX_MEM_branch_tacken,
    input  stall, forwardSignal, div_busy, div_done, stall_cycles
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_uses_rs, ID_uses_rt, ID_Beq, ID_div_start, ID_hilo_use,
           ID_EX_RegWrite, ID_EX_Mem2Reg, ID_EX_Rd,
           EX_MEM_RegWrite, EX_MEM_Mem2Reg, EX_MEM_Rd,
           MEM_WB_RegWrite, MEM_WB_Rd, EX_MEM_branch_tacken,
    output stall, forwardSignal, div_busy, div_done, stall_cycles
  );

endinterface

// File: rtl/pipe_hazard_ctrl_div_sequencer.sv
// div_sequencer
//   Sequences the iterative divider: an accepted start holds BUSY for
//   DIV_CYCLES cycles, then DONE for one cycle while HI/LO become valid.
//   A start accepted in DONE re-enters BUSY with no IDLE gap.
//   Ports: clk, rst (sync, active high), start (accepted start request),
//          busy (state BUSY), done (state DONE, one-cycle pulse).
//
//   state | meaning
//   IDLE  | no divide in flight
//   BUSY  | iterating, count runs DIV_CYCLES-1 down to 0
//   DONE  | HI/LO valid this cycle
module div_sequencer
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam logic [DIV_CNT_W-1:0] CNT_LOAD = DIV_CNT_W'(DIV_CYCLES - 1);

  div_state_t           state, state_nxt;
  logic [DIV_CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (cnt != '0) cnt_nxt   = cnt - 1'b1;
        else           state_nxt = DONE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard and multi-cycle sequencing controller for the 5-stage MIPS
//   pipeline. Computes the ID-stage stall and operand forward selects and
//   sequences the iterative divider through div_sequencer.
//   Ports:
//     clk  : pipeline clock
//     rst  : synchronous, active-high reset
//     bus  : pipe_hazard_ctrl_if.slave -- ID decode fields, ID/EX, EX/MEM,
//            MEM/WB tags and branch squash in; stall, forwardSignal
//            ([3:2] Rs, [1:0] Rt), div_busy, div_done, stall_cycles out
//   Build option: PIPE_HAZARD_STATS_EN adds a wrapping 32-bit count of
//   stalled cycles on stall_cycles; without it stall_cycles reads 0.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  logic rs_id_ex, rt_id_ex, rs_ex_mem, rt_ex_mem, rs_mem_wb, rt_mem_wb;
  logic load_use, branch_hz, div_hz, stall_int;
  logic div_start, div_busy, div_done;
  logic [1:0] fwd_rs, fwd_rt;

  assign rs_id_ex  = reg_match(bus.ID_Rs, bus.ID_EX_Rd);
  assign rt_id_ex  = reg_match(bus.ID_Rt, bus.ID_EX_Rd);
  assign rs_ex_mem = reg_match(bus.ID_Rs, bus.EX_MEM_Rd);
  assign rt_ex_mem = reg_match(bus.ID_Rt, bus.EX_MEM_Rd);
  assign rs_mem_wb = reg_match(bus.ID_Rs, bus.MEM_WB_Rd);
  assign rt_mem_wb = reg_match(bus.ID_Rt, bus.MEM_WB_Rd);

  assign load_use = bus.ID_EX_RegWrite && bus.ID_EX_Mem2Reg &&
                    ((bus.ID_uses_rs && rs_id_ex) || (bus.ID_uses_rt && rt_id_ex));

  // A branch compares in ID, so any ALU result still in EX and any load
  // still in MEM is not yet forwardable to it.
  assign branch_hz = bus.ID_Beq &&
                     ((bus.ID_EX_RegWrite && (rs_id_ex || rt_id_ex)) ||
                      (bus.EX_MEM_RegWrite && bus.EX_MEM_Mem2Reg && (rs_ex_mem || rt_ex_mem)));

  assign div_hz = div_busy && (bus.ID_div_start || bus.ID_hilo_use);

  // A squashed ID instruction must not hold the pipe, otherwise the taken
  // branch target fetch would be delayed by a dead instruction.
  assign stall_int = (load_use || branch_hz || div_hz) && !bus.EX_MEM_branch_tacken && !rst;

  always_comb begin
    fwd_rs = FWD_REG;
    fwd_rt = FWD_REG;
    if (!rst) begin
      if (bus.EX_MEM_RegWrite && !bus.EX_MEM_Mem2Reg && rs_ex_mem) fwd_rs = FWD_EXMEM;
      else if (bus.MEM_WB_RegWrite && rs_mem_wb)                   fwd_rs = FWD_WB;
      if (bus.EX_MEM_RegWrite && !bus.EX_MEM_Mem2Reg && rt_ex_mem) fwd_rt = FWD_EXMEM;
      else if (bus.MEM_WB_RegWrite && rt_mem_wb)                   fwd_rt = FWD_WB;
    end
  end

  assign div_start = bus.ID_div_start && !stall_int && !bus.EX_MEM_branch_tacken;

  div_sequencer #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_sequencer (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .busy  (div_busy),
    .done  (div_done)
  );

  assign bus.stall         = stall_int;
  assign bus.forwardSignal = {fwd_rs, fwd_rt};
  assign bus.div_busy      = div_busy;
  assign bus.div_done      = div_done;

`ifdef PIPE_HAZARD_STATS_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst)            stall_cnt <= '0;
    else if (stall_int) stall_cnt <= stall_cnt + 32'd1;
  end

  assign bus.stall_cycles = stall_cnt;
`else
  assign bus.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Self-checking bench for pipe_hazard_ctrl (DIV_CYCLES=4). Each step pushes
//   its expected outputs to a scoreboard queue, which is popped and compared
//   at the following falling edge. Directed steps carry hand-derived values;
//   the random phase uses a small reference model kept in this file.
module tb_pipe_hazard_ctrl;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(
    .DIV_CYCLES (DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       tag;
    logic        s;
    logic [3:0]  f;
    logic        b;
    logic        d;
    logic [31:0] c;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          div_n = 0;       // 0 idle, 1..DIV busy cycle, DIV+1 done cycle
  logic        cur_es = 1'b0;
  logic [31:0] stat_cnt = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    bus.ID_Rs = 5'd0;              bus.ID_Rt = 5'd0;
    bus.ID_uses_rs = 1'b0;         bus.ID_uses_rt = 1'b0;
    bus.ID_Beq = 1'b0;             bus.ID_div_start = 1'b0;
    bus.ID_hilo_use = 1'b0;
    bus.ID_EX_RegWrite = 1'b0;     bus.ID_EX_Mem2Reg = 1'b0;   bus.ID_EX_Rd = 5'd0;
    bus.EX_MEM_RegWrite = 1'b0;    bus.EX_MEM_Mem2Reg = 1'b0;  bus.EX_MEM_Rd = 5'd0;
    bus.MEM_WB_RegWrite = 1'b0;    bus.MEM_WB_Rd = 5'd0;
    bus.EX_MEM_branch_tacken = 1'b0;
  endtask

  function automatic logic m_match(input logic [4:0] s, input logic [4:0] rd);
    return (rd == s) && (rd != 5'd0);
  endfunction

  function automatic logic m_busy();
    return (div_n >= 1) && (div_n <= DIV);
  endfunction

  function automatic logic m_done();
    return div_n == DIV + 1;
  endfunction

  function automatic logic m_stall();
    logic       h;
    logic [4:0] s;
    logic       u;
    h = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s = (i == 0) ? bus.ID_Rs : bus.ID_Rt;
      u = (i == 0) ? bus.ID_uses_rs : bus.ID_uses_rt;
      if (bus.ID_EX_RegWrite && bus.ID_EX_Mem2Reg && u && m_match(s, bus.ID_EX_Rd)) h = 1'b1;
      if (bus.ID_Beq && bus.ID_EX_RegWrite && m_match(s, bus.ID_EX_Rd)) h = 1'b1;
      if (bus.ID_Beq && bus.EX_MEM_RegWrite && bus.EX_MEM_Mem2Reg && m_match(s, bus.EX_MEM_Rd)) h = 1'b1;
    end
    if (m_busy() && (bus.ID_div_start || bus.ID_hilo_use)) h = 1'b1;
    if (rst || bus.EX_MEM_branch_tacken) h = 1'b0;
    return h;
  endfunction

  function automatic logic [3:0] m_fwd();
    logic [1:0] sel [2];
    logic [4:0] s;
    for (int i = 0; i < 2; i++) begin
      s = (i == 0) ? bus.ID_Rs : bus.ID_Rt;
      sel[i] = 2'b00;
      if (bus.MEM_WB_RegWrite && m_match(s, bus.MEM_WB_Rd)) sel[i] = 2'b10;
      if (bus.EX_MEM_RegWrite && !bus.EX_MEM_Mem2Reg && m_match(s, bus.EX_MEM_Rd)) sel[i] = 2'b01;
      if (rst) sel[i] = 2'b00;
    end
    return {sel[0], sel[1]};
  endfunction

  task automatic step(input string tag, input logic es, input logic [3:0] ef,
                      input logic eb, input logic ed);
    exp_t e;
    e.tag = tag; e.s = es; e.f = ef; e.b = eb; e.d = ed;
`ifdef PIPE_HAZARD_STATS_EN
    e.c = stat_cnt;
`else
    e.c = 32'd0;
`endif
    sb.push_back(e);
    cur_es = es;
    @(negedge clk);
    if (sb.size() == 0) begin
      check_val("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check_val({e.tag, ".stall"}, {31'd0, bus.stall}, {31'd0, e.s});
      check_val({e.tag, ".fwd"},   {28'd0, bus.forwardSignal}, {28'd0, e.f});
      check_val({e.tag, ".busy"},  {31'd0, bus.div_busy}, {31'd0, e.b});
      check_val({e.tag, ".done"},  {31'd0, bus.div_done}, {31'd0, e.d});
      check_val({e.tag, ".scnt"},  bus.stall_cycles, e.c);
    end
    @(posedge clk);
    if (rst) begin
      div_n    = 0;
      stat_cnt = '0;
    end else begin
      if (cur_es) stat_cnt = stat_cnt + 32'd1;
      if (bus.ID_div_start && !cur_es && !bus.EX_MEM_branch_tacken &&
          (div_n == 0 || div_n == DIV + 1))
        div_n = 1;
      else if (div_n == DIV + 1)
        div_n = 0;
      else if (div_n != 0)
        div_n = div_n + 1;
    end
    #1;
  endtask

  task automatic rstep(input string tag);
    step(tag, m_stall(), m_fwd(), m_busy(), m_done());
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    @(posedge clk);
    #1;
    step("reset", 1'b0, 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;

    // Load-use: three stalled cycles, then Rd=0 never matches.
    clear_in();
    bus.ID_EX_RegWrite = 1'b1; bus.ID_EX_Mem2Reg = 1'b1; bus.ID_EX_Rd = 5'd5;
    bus.ID_Rs = 5'd5; bus.ID_uses_rs = 1'b1;
    step("lu1", 1'b1, 4'b0000, 1'b0, 1'b0);
    step("lu2", 1'b1, 4'b0000, 1'b0, 1'b0);
    step("lu3", 1'b1, 4'b0000, 1'b0, 1'b0);
    bus.ID_EX_Rd = 5'd0;
    step("lu_r0", 1'b0, 4'b0000, 1'b0, 1'b0);

    // Branch forwarding: EX_MEM wins over MEM_WB, then MEM_WB alone.
    clear_in();
    bus.ID_Beq = 1'b1; bus.ID_Rs = 5'd8; bus.ID_uses_rs = 1'b1;
    bus.EX_MEM_RegWrite = 1'b1; bus.EX_MEM_Rd = 5'd8;
    bus.MEM_WB_RegWrite = 1'b1; bus.MEM_WB_Rd = 5'd8;
    step("bfwd_exmem", 1'b0, 4'b0100, 1'b0, 1'b0);
    bus.EX_MEM_Rd = 5'd9;
    step("bfwd_wb", 1'b0, 4'b1000, 1'b0, 1'b0);

    // Branch on a load still in MEM, then forwarded from WB.
    clear_in();
    bus.ID_Beq = 1'b1; bus.ID_Rt = 5'd3; bus.ID_uses_rt = 1'b1;
    bus.EX_MEM_RegWrite = 1'b1; bus.EX_MEM_Mem2Reg = 1'b1; bus.EX_MEM_Rd = 5'd3;
    step("bload_stall", 1'b1, 4'b0000, 1'b0, 1'b0);
    bus.EX_MEM_RegWrite = 1'b0; bus.EX_MEM_Mem2Reg = 1'b0; bus.EX_MEM_Rd = 5'd0;
    bus.MEM_WB_RegWrite = 1'b1; bus.MEM_WB_Rd = 5'd3;
    step("bload_wb", 1'b0, 4'b0010, 1'b0, 1'b0);

    // Squash: start ignored, load-use suppressed.
    clear_in();
    bus.ID_div_start = 1'b1; bus.EX_MEM_branch_tacken = 1'b1;
    bus.ID_EX_RegWrite = 1'b1; bus.ID_EX_Mem2Reg = 1'b1; bus.ID_EX_Rd = 5'd7;
    bus.ID_Rs = 5'd7; bus.ID_uses_rs = 1'b1;
    step("sq_start", 1'b0, 4'b0000, 1'b0, 1'b0);
    clear_in();
    step("sq_idle", 1'b0, 4'b0000, 1'b0, 1'b0);

    // Divide, HI/LO interlock, back-to-back start in DONE.
    bus.ID_div_start = 1'b1;
    step("div_go", 1'b0, 4'b0000, 1'b0, 1'b0);
    bus.ID_div_start = 1'b0;
    step("div_c1", 1'b0, 4'b0000, 1'b1, 1'b0);
    bus.ID_hilo_use = 1'b1;
    step("div_c2_mfhi", 1'b1, 4'b0000, 1'b1, 1'b0);
    bus.ID_hilo_use = 1'b0;
    step("div_c3", 1'b0, 4'b0000, 1'b1, 1'b0);
    step("div_c4", 1'b0, 4'b0000, 1'b1, 1'b0);
    bus.ID_hilo_use = 1'b1; bus.ID_div_start = 1'b1;
    step("div_c5_b2b", 1'b0, 4'b0000, 1'b0, 1'b1);
    bus.ID_hilo_use = 1'b0;
    step("div_c6_divwait", 1'b1, 4'b0000, 1'b1, 1'b0);
    bus.ID_div_start = 1'b0;
    step("div_c7", 1'b0, 4'b0000, 1'b1, 1'b0);
    step("div_c8", 1'b0, 4'b0000, 1'b1, 1'b0);
    step("div_c9", 1'b0, 4'b0000, 1'b1, 1'b0);
    step("div_c10", 1'b0, 4'b0000, 1'b0, 1'b1);
    step("div_idle", 1'b0, 4'b0000, 1'b0, 1'b0);

    // Reset mid-divide: outputs forced, divide abandoned.
    bus.ID_div_start = 1'b1;
    step("rd_go", 1'b0, 4'b0000, 1'b0, 1'b0);
    bus.ID_div_start = 1'b0;
    step("rd_busy", 1'b0, 4'b0000, 1'b1, 1'b0);
    rst = 1'b1;
    bus.ID_hilo_use = 1'b1;
    bus.ID_Rs = 5'd8; bus.EX_MEM_RegWrite = 1'b1; bus.EX_MEM_Rd = 5'd8;
    step("rd_rst", 1'b0, 4'b0000, 1'b1, 1'b0);
    rst = 1'b0;
    clear_in();
    step("rd_after", 1'b0, 4'b0000, 1'b0, 1'b0);

    // Random traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      bus.ID_Rs = 5'($urandom_range(0, 3));
      bus.ID_Rt = 5'($urandom_range(0, 3));
      bus.ID_uses_rs = 1'($urandom);
      bus.ID_uses_rt = 1'($urandom);
      bus.ID_Beq = ($urandom_range(0, 3) == 0);
      bus.ID_div_start = ($urandom_range(0, 3) == 0);
      bus.ID_hilo_use = ($urandom_range(0, 2) == 0);
      bus.ID_EX_RegWrite = 1'($urandom);
      bus.ID_EX_Mem2Reg = 1'($urandom);
      bus.ID_EX_Rd = 5'($urandom_range(0, 3));
      bus.EX_MEM_RegWrite = 1'($urandom);
      bus.EX_MEM_Mem2Reg = 1'($urandom);
      bus.EX_MEM_Rd = 5'($urandom_range(0, 3));
      bus.MEM_WB_RegWrite = 1'($urandom);
      bus.MEM_WB_Rd = 5'($urandom_range(0, 3));
      bus.EX_MEM_branch_tacken = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 49) == 0);
      rstep("rand");
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and multi-cycle sequencing controller for the 5-stage MIPS pipeline. Produces the ID-stage `stall` and `forwardSignal` consumed by the decode stage, and sequences the iterative divider, holding dependent instructions in ID until HI/LO are valid. Sits beside the pipeline registers; its inputs are IF/ID decode fields and ID/EX, EX/MEM, MEM/WB register tags.

## Interface
Parameters:
- `DIV_CYCLES`, 32: divider iteration count, 2..64.

Ports:
- `clk`  in  1  pipeline clock.
- `rst`  in  1  synchronous, active-high reset.
- `ID_Rs`, `ID_Rt`  in  5  source registers of the instruction in ID.
- `ID_uses_rs`, `ID_uses_rt`  in  1  instruction in ID reads that source.
- `ID_Beq`  in  1  branch in ID compares operands in ID.
- `ID_div_start`  in  1  DIV/DIVU in ID.
- `ID_hilo_use`  in  1  MFHI/MFLO/MTHI/MTLO/MULT in ID.
- `ID_EX_RegWrite`, `ID_EX_Mem2Reg`  in  1  ID/EX control.
- `ID_EX_Rd`  in  5  ID/EX destination.
- `EX_MEM_RegWrite`, `EX_MEM_Mem2Reg`  in  1  EX/MEM control.
- `EX_MEM_Rd`  in  5  EX/MEM destination.
- `MEM_WB_RegWrite`  in  1  MEM/WB write enable.
- `MEM_WB_Rd`  in  5  MEM/WB destination.
- `EX_MEM_branch_tacken`  in  1  taken branch/jump resolving; squashes the instruction in ID.
- `stall`  out  1  hold PC and IF/ID, bubble into ID/EX.
- `forwardSignal`  out  4  [3:2] Rs select, [1:0] Rt select: 00 regfile, 01 EX_MEM aluout, 10 WBvalue.
- `div_busy`  out  1  divider iterating.
- `div_done`  out  1  one-cycle pulse, HI/LO valid.
- `stall_cycles`  out  32  stall counter (see Configuration).

## Operation
- Match(x, Rd): `Rd != 0 && Rd == x`; register 0 never matches.
- Load-use stall: `ID_EX_RegWrite && ID_EX_Mem2Reg` and ID_EX_Rd matches a used source.
- Branch stall (only when `ID_Beq`): ID_EX_RegWrite with ID_EX_Rd matching Rs or Rt; or EX_MEM_RegWrite && EX_MEM_Mem2Reg with EX_MEM_Rd matching.
- Divider stall: state BUSY and (`ID_div_start` or `ID_hilo_use`).
- `stall` = OR of the above, forced 0 while `EX_MEM_branch_tacken` (ID being squashed) or `rst`.
- Forward per source: EX_MEM_RegWrite && !EX_MEM_Mem2Reg && match -> 01; else MEM_WB_RegWrite && match -> 10; else 00. EX_MEM wins over MEM_WB. Forced 0000 under `rst`.
- Divider FSM IDLE/BUSY/DONE:
  - IDLE or DONE: `ID_div_start && !stall && !EX_MEM_branch_tacken` -> BUSY, count := DIV_CYCLES-1.
  - BUSY: count != 0 -> decrement; count == 0 -> DONE.
  - DONE: no accepted start -> IDLE.
- `div_busy` = (state == BUSY); `div_done` = (state == DONE).
- Reset mid-divide: state IDLE, count 0 at next edge; the divide is abandoned.

## Timing
- `stall`, `forwardSignal`: combinational, same cycle as inputs.
- `div_busy`, `div_done`: registered, state-decoded.
- Start accepted at edge k: `div_busy` high for cycles k+1..k+DIV_CYCLES; `div_done` at k+DIV_CYCLES+1.
- Back-to-back DIV in the DONE cycle is accepted with zero IDLE gap.
- Reset values: state IDLE, count 0, `div_busy` 0, `div_done` 0, `stall` 0, `forwardSignal` 0000, `stall_cycles` 0.

## Configuration
- `PIPE_HAZARD_STATS_EN` defined: `stall_cycles` increments on every cycle with `stall`=1 and wraps at 2^32. Cleared by `rst`.
- Undefined: no counter logic; `stall_cycles` tied to 0.

## Structure
- Shared package: forward select constants `FWD_REG`=2'b00, `FWD_EXMEM`=2'b01, `FWD_WB`=2'b10; divider state enum IDLE/BUSY/DONE.
- Sub-module `div_sequencer`: FSM and down-counter. Ports: clk, rst, start, busy, done.
- Hazard compare and forward muxing stay in the top.

## Test plan
- Load-use: ID_EX Mem2Reg=1, RegWrite=1, Rd=5; ID Rs=5, uses_rs=1 -> `stall`=1. Same with Rd=0 -> `stall`=0.
- Branch forward: ID_Beq=1, Rs=8; EX_MEM RegWrite=1, Mem2Reg=0, Rd=8; MEM_WB Rd=8 -> `forwardSignal[3:2]`=01, `stall`=0. EX_MEM Rd=9 instead -> 10.
- Branch on load: ID_Beq=1, Rt=3; EX_MEM Mem2Reg=1, Rd=3 -> `stall`=1. Next cycle, MEM_WB Rd=3 -> `stall`=0, `forwardSignal[1:0]`=10.
- Divide: DIV_CYCLES=4, start at edge 0 -> `div_busy` cycles 1-4, `div_done` cycle 5. MFHI in ID during cycle 2 -> `stall`=1; MFHI during cycle 5 -> `stall`=0.
- Squash and reset: start with `EX_MEM_branch_tacken`=1 -> stays IDLE. `rst` during BUSY -> IDLE, `div_busy`=0 next cycle.
- Stats (macro on): 3 load-use stall cycles -> `stall_cycles`=3. Macro off -> reads 0.
